rsa_uart_sequencer: RTL and testbench
=====================================

RSA_UART_SEQUENCER -- requirements
Module: rsa_uart_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand/result width in bits; legal values are multiples of 8, and NB = WIDTH/8 bytes per operand.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, giving the maximum inter-byte gap inside a frame.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port rx_valid_in, input, 1 bit: one-cycle pulse from the UART receiver when a new byte is available.
REQ-006 SHALL have port rx_byte_in, input, 8 bits: the received byte, valid while rx_valid_in is high.
REQ-007 SHALL have port expmod_start_out, output, 1 bit: one-cycle start pulse to exponent_modulus (ready_in).
REQ-008 SHALL have ports value_out, exponent_out and modulus_out, outputs, WIDTH bits each: operands driven to exponent_modulus.
REQ-009 SHALL have port expmod_busy_in, input, 1 bit: exponent_modulus busy.
REQ-010 SHALL have port expmod_valid_in, input, 1 bit: one-cycle result-valid pulse from exponent_modulus.
REQ-011 SHALL have port expmod_result_in, input, WIDTH bits: the modexp result.
REQ-012 SHALL have port tx_trigger_out, output, 1 bit: one-cycle pulse to the UART transmitter.
REQ-013 SHALL have port tx_data_out, output, 8 bits: the byte to transmit, valid with tx_trigger_out.
REQ-014 SHALL have port tx_busy_in, input, 1 bit: transmitter busy.
REQ-015 SHALL have port busy_out, output, 1 bit: high in every state except RX.
REQ-016 SHALL have port result_out, output, WIDTH bits: the last result latched, for LED display.
REQ-017 SHALL have port drop_count_out, output, 8 bits: a saturating count of discarded bytes and frames.

Function
REQ-018 SHALL implement the FSM states RX, LAUNCH, WAIT, TX_LOAD and TX_WAIT.
REQ-019 SHALL, in RX, shift received bytes MSB-first into a 3*NB-byte frame in the order value, exponent, modulus, and count them.
REQ-020 SHALL, on the 3*NB-th byte, load value_out, exponent_out and modulus_out from the frame and go to LAUNCH on the next cycle.
REQ-021 SHALL, in LAUNCH with modulus non-zero, assert expmod_start_out for exactly one cycle, but only when expmod_busy_in is low; otherwise it waits in LAUNCH. It then goes to WAIT.
REQ-022 SHALL, in LAUNCH with modulus equal to zero, not start exponent_modulus, set the result to all ones, and go to TX_LOAD.
REQ-023 SHALL hold the operand outputs constant from LAUNCH until the FSM returns to RX.
REQ-024 SHALL, in WAIT on expmod_valid_in, latch expmod_result_in into result_out and go to TX_LOAD.
REQ-025 SHALL, in TX_LOAD with tx_busy_in low, drive result byte k (MSB first, k = NB-1..0) on tx_data_out, pulse tx_trigger_out for one cycle, and go to TX_WAIT.
REQ-026 SHALL, in TX_WAIT, ignore tx_busy_in for one cycle, then wait for tx_busy_in low; it returns to TX_LOAD while bytes remain, otherwise to RX with the byte counter cleared.
REQ-027 SHALL, when more than TIMEOUT_CYCLES pass without rx_valid_in in RX with 1 to 3*NB-1 bytes held, discard the partial frame, clear the byte counter, and increment drop_count_out.
REQ-028 SHALL, while not in RX, drop each rx_valid_in byte and increment drop_count_out.
REQ-029 SHALL saturate drop_count_out at 255.
REQ-030 SHALL, when rx_valid_in coincides with the timeout cycle, take the timeout first and store the byte as byte 0 of a new frame.
REQ-031 SHALL ignore expmod_valid_in in every state other than WAIT.

Reset
REQ-032 SHALL, on rst_in, go to RX and zero the byte counter, timeout counter, operand outputs, result_out and drop_count_out.
REQ-033 SHALL drive expmod_start_out, tx_trigger_out, tx_data_out and busy_out low during reset and in the cycle after it.
REQ-034 SHALL, on reset mid-operation, abandon the job with no further start or trigger pulses; an in-flight expmod_valid_in after reset is ignored.

Verification
REQ-035 SHALL verify that bytes 00 05 00 48 04 31, with an expmod stub returning 0x0070 after 40 cycles, give one start pulse with value/exp/mod = 5/72/1073, then tx bytes 00, 70, with result_out = 0x0070.
REQ-036 SHALL verify that bytes 00 05 00 02 00 00 give no start pulse and tx bytes FF, FF.
REQ-037 SHALL verify that 3 bytes followed by a TIMEOUT_CYCLES+1 idle gap, then a full valid frame, give drop_count_out = 1 and a correct single result.
REQ-038 SHALL verify that 2 extra bytes injected during WAIT give drop_count_out = 2 and do not corrupt the following frame.
REQ-039 SHALL verify that rst_in asserted in WAIT, followed by a stub valid pulse, gives no tx_trigger_out, FSM in RX, and all outputs zero.
REQ-040 SHALL verify that tx_busy_in held high for 500 cycles after each trigger still delivers both bytes in order, one trigger per byte.

Source files
------------

// File: rtl/rsa_uart_sequencer.sv
// rsa_uart_sequencer
//
// Collects a frame of three big-endian operands (value, exponent, modulus)
// from a UART receiver, launches one exponent_modulus job, and then sends
// the WIDTH-bit result back out through a UART transmitter, MSB byte first.
// A zero modulus skips the job and returns all ones. Bytes that arrive while
// a job is in progress, and partial frames that stall, are discarded and
// counted.
//
// Ports
//   clk_in            single clock, rising edge
//   rst_in            synchronous, active-high reset
//   rx_valid_in       one-cycle strobe, rx_byte_in holds a new byte
//   rx_byte_in        received byte
//   expmod_start_out  one-cycle start strobe to exponent_modulus
//   value_out         operand: base
//   exponent_out      operand: exponent
//   modulus_out       operand: modulus
//   expmod_busy_in    exponent_modulus is busy
//   expmod_valid_in   one-cycle strobe, expmod_result_in is valid
//   expmod_result_in  modexp result
//   tx_trigger_out    one-cycle strobe, tx_data_out is the byte to send
//   tx_data_out       byte to transmit
//   tx_busy_in        transmitter busy
//   busy_out          high whenever the FSM is not collecting bytes
//   result_out        last result latched (LED display)
//   drop_count_out    saturating count of discarded bytes and frames
//   state_out         current FSM state (debug)
//
// Handshakes: rx_valid_in and expmod_valid_in are single-cycle strobes with
// no back-pressure; a byte or result is taken in the cycle its strobe is high
// or never. expmod_start_out is raised only in a cycle where expmod_busy_in
// is low, and tx_trigger_out only in a cycle where tx_busy_in is low.

module rsa_uart_sequencer #(
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rx_valid_in,
  input  logic [7:0]       rx_byte_in,
  output logic             expmod_start_out,
  output logic [WIDTH-1:0] value_out,
  output logic [WIDTH-1:0] exponent_out,
  output logic [WIDTH-1:0] modulus_out,
  input  logic             expmod_busy_in,
  input  logic             expmod_valid_in,
  input  logic [WIDTH-1:0] expmod_result_in,
  output logic             tx_trigger_out,
  output logic [7:0]       tx_data_out,
  input  logic             tx_busy_in,
  output logic             busy_out,
  output logic [WIDTH-1:0] result_out,
  output logic [7:0]       drop_count_out,
  output logic [2:0]       state_out
);

  localparam int NB          = WIDTH / 8;
  localparam int FRAME_BYTES = 3 * NB;
  localparam int FW          = 3 * WIDTH;
  localparam int BCW         = $clog2(FRAME_BYTES + 1);
  localparam int TCW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TXW         = $clog2(NB + 1);
  localparam logic [TCW-1:0] TIMEOUT_LIM = TCW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_RX      = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_TX_LOAD = 3'd3,
    S_TX_WAIT = 3'd4
  } state_t;

  state_t           state;
  logic [BCW-1:0]   byte_cnt;
  logic [TCW-1:0]   idle_cnt;
  // Holds all but the final byte of a frame; the final byte is taken
  // straight from rx_byte_in when the operands are loaded.
  logic [FW-9:0]    frame;
  logic [WIDTH-1:0] tx_shift;
  logic [TXW-1:0]   tx_left;    // bytes still to send after the current one
  logic             tx_holdoff; // masks tx_busy_in in the cycle after a trigger

  logic [FW-1:0] frame_next;
  logic          timeout_hit;
  logic          last_byte;
  logic          drop_event;

  assign frame_next = {frame, rx_byte_in};
  // idle_cnt equals TIMEOUT_LIM on the first cycle after TIMEOUT_CYCLES
  // idle cycles; that cycle is the timeout, even if a byte arrives in it.
  assign timeout_hit = (state == S_RX) && (byte_cnt != '0) && (idle_cnt == TIMEOUT_LIM);
  assign last_byte   = (byte_cnt == BCW'(FRAME_BYTES - 1));
  assign drop_event  = timeout_hit || (rx_valid_in && (state != S_RX));

  assign busy_out  = (state != S_RX);
  assign state_out = state;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= S_RX;
      byte_cnt         <= '0;
      idle_cnt         <= '0;
      frame            <= '0;
      tx_shift         <= '0;
      tx_left          <= '0;
      tx_holdoff       <= 1'b0;
      value_out        <= '0;
      exponent_out     <= '0;
      modulus_out      <= '0;
      result_out       <= '0;
      drop_count_out   <= '0;
      expmod_start_out <= 1'b0;
      tx_trigger_out   <= 1'b0;
      tx_data_out      <= '0;
    end else begin
      expmod_start_out <= 1'b0;
      tx_trigger_out   <= 1'b0;

      if (drop_event && (drop_count_out != 8'hFF)) begin
        drop_count_out <= drop_count_out + 8'd1;
      end

      case (state)
        S_RX: begin
          if (timeout_hit) begin
            // Discard the stalled frame; a coincident byte opens a new one.
            idle_cnt <= '0;
            if (rx_valid_in) begin
              frame    <= (FW-8)'(rx_byte_in);
              byte_cnt <= BCW'(1);
            end else begin
              byte_cnt <= '0;
            end
          end else if (rx_valid_in) begin
            idle_cnt <= '0;
            frame    <= frame_next[FW-9:0];
            if (last_byte) begin
              value_out    <= frame_next[FW-1 -: WIDTH];
              exponent_out <= frame_next[2*WIDTH-1 -: WIDTH];
              modulus_out  <= frame_next[WIDTH-1:0];
              byte_cnt     <= BCW'(FRAME_BYTES);
              state        <= S_LAUNCH;
            end else begin
              byte_cnt <= byte_cnt + BCW'(1);
            end
          end else if (byte_cnt != '0) begin
            idle_cnt <= idle_cnt + TCW'(1);
          end else begin
            idle_cnt <= '0;
          end
        end

        S_LAUNCH: begin
          if (modulus_out == '0) begin
            result_out <= '1;
            tx_shift   <= '1;
            tx_left    <= TXW'(NB - 1);
            state      <= S_TX_LOAD;
          end else if (!expmod_busy_in) begin
            expmod_start_out <= 1'b1;
            state            <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (expmod_valid_in) begin
            result_out <= expmod_result_in;
            tx_shift   <= expmod_result_in;
            tx_left    <= TXW'(NB - 1);
            state      <= S_TX_LOAD;
          end
        end

        S_TX_LOAD: begin
          if (!tx_busy_in) begin
            tx_data_out    <= tx_shift[WIDTH-1 -: 8];
            tx_trigger_out <= 1'b1;
            tx_shift       <= tx_shift << 8;
            tx_holdoff     <= 1'b1;
            state          <= S_TX_WAIT;
          end
        end

        S_TX_WAIT: begin
          // The transmitter raises busy one cycle after the trigger, so the
          // first cycle here would otherwise see a stale "not busy".
          if (tx_holdoff) begin
            tx_holdoff <= 1'b0;
          end else if (!tx_busy_in) begin
            if (tx_left == '0) begin
              byte_cnt <= '0;
              idle_cnt <= '0;
              state    <= S_RX;
            end else begin
              tx_left <= tx_left - TXW'(1);
              state   <= S_TX_LOAD;
            end
          end
        end

        default: state <= S_RX;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_uart_sequencer.sv
// Testbench for rsa_uart_sequencer (WIDTH=16, short timeout).
// Clock/reset block, driver tasks, expmod and UART-tx responders, a
// scoreboard of expected tx bytes (exp_q) and a final report.

module tb_rsa_uart_sequencer;

  localparam int WIDTH    = 16;
  localparam int TO       = 50;
  localparam int STUB_LAT = 40;
  localparam logic [2:0] ST_RX = 3'd0;

  // ---------------- clock / reset ----------------
  logic clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  logic             rst = 1'b1;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_byte = 8'h00;
  logic             expmod_start;
  logic [WIDTH-1:0] value, exponent, modulus;
  logic             expmod_busy = 1'b0;
  logic             expmod_valid = 1'b0;
  logic [WIDTH-1:0] expmod_result = '0;
  logic             tx_trigger;
  logic [7:0]       tx_data;
  logic             tx_busy = 1'b0;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic [7:0]       drop_count;
  logic [2:0]       state;

  rsa_uart_sequencer #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk_in           (clk_100mhz),
    .rst_in           (rst),
    .rx_valid_in      (rx_valid),
    .rx_byte_in       (rx_byte),
    .expmod_start_out (expmod_start),
    .value_out        (value),
    .exponent_out     (exponent),
    .modulus_out      (modulus),
    .expmod_busy_in   (expmod_busy),
    .expmod_valid_in  (expmod_valid),
    .expmod_result_in (expmod_result),
    .tx_trigger_out   (tx_trigger),
    .tx_data_out      (tx_data),
    .tx_busy_in       (tx_busy),
    .busy_out         (busy),
    .result_out       (result),
    .drop_count_out   (drop_count),
    .state_out        (state)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int trig_cnt = 0;
  int exp_drop = 0;
  int tx_hold = 3;
  int s0, t0;
  logic ext_busy = 1'b0;
  int inject_req = 0;
  int inject_done = 0;
  logic [15:0] inject_data = 16'h0000;
  logic [15:0] last_res = 16'h0000;
  logic [7:0] exp_q[$];
  logic [7:0] sb_exp;

  // Reference: plain square-and-multiply modular exponentiation.
  function automatic logic [15:0] modexp(input logic [15:0] b, input logic [15:0] e,
                                         input logic [15:0] m);
    longint unsigned r, x, mm;
    if (m == 16'h0000) return 16'hFFFF;
    mm = longint'(m);
    r  = 1 % mm;
    x  = longint'(b) % mm;
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[15:0];
  endfunction

  // What the sequencer must report for a frame {value, exponent, modulus}.
  function automatic logic [15:0] model_result(input logic [47:0] f);
    if (f[15:0] == 16'h0000) return 16'hFFFF;
    return modexp(f[47:32], f[31:16], f[15:0]);
  endfunction

  // ---------------- exponent_modulus responder ----------------
  int stub_cnt = 0;
  logic [15:0] stub_res = 16'h0000;
  always @(negedge clk_100mhz) begin
    expmod_valid = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        expmod_valid  = 1'b1;
        expmod_result = stub_res;
      end
    end else if (inject_req != inject_done) begin
      expmod_valid  = 1'b1;
      expmod_result = inject_data;
      inject_done++;
    end
    if (expmod_start) begin
      start_cnt++;
      stub_res = modexp(value, exponent, modulus);
      stub_cnt = STUB_LAT;
    end
    expmod_busy = (stub_cnt > 0) || ext_busy;
  end

  // ---------------- UART tx responder + scoreboard ----------------
  int tx_cnt = 0;
  always @(negedge clk_100mhz) begin
    if (tx_cnt > 0) tx_cnt--;
    if (tx_trigger) begin
      trig_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL tx_byte: actual=%02h required=none", tx_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (tx_data !== sb_exp) begin
          bad++;
          $display("FAIL tx_byte: actual=%02h required=%02h", tx_data, sb_exp);
        end
      end
      tx_cnt = tx_hold;
    end
    tx_busy = (tx_cnt > 0);
  end

  // ---------------- driver / check tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk_100mhz);
    rx_valid = 1'b0;
  endtask

  // gap < 0 picks a random 0..3 idle cycles between bytes.
  task automatic send_frame(input logic [47:0] f, input int gap);
    int g;
    for (int i = 5; i >= 0; i--) begin
      send_byte(f[i*8 +: 8]);
      if (i != 0) begin
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        repeat (g) @(negedge clk_100mhz);
      end
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk_100mhz);
      n++;
    end
    check({name, "_done"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic start_frame(input string name, input logic [47:0] f, input int gap,
                             input logic [15:0] res);
    s0 = start_cnt;
    t0 = trig_cnt;
    send_frame(f, gap);
    check({name, "_value"}, {16'd0, value}, {16'd0, f[47:32]});
    check({name, "_exp"}, {16'd0, exponent}, {16'd0, f[31:16]});
    check({name, "_mod"}, {16'd0, modulus}, {16'd0, f[15:0]});
    exp_q.push_back(res[15:8]);
    exp_q.push_back(res[7:0]);
  endtask

  task automatic finish_frame(input string name, input int starts, input logic [15:0] res,
                              input int budget);
    wait_idle(name, budget);
    check({name, "_starts"}, start_cnt - s0, starts);
    check({name, "_trigs"}, trig_cnt - t0, 2);
    check({name, "_result"}, {16'd0, result}, {16'd0, res});
    check({name, "_drops"}, {24'd0, drop_count}, exp_drop);
    check({name, "_pending"}, exp_q.size(), 0);
    last_res = res;
  endtask

  task automatic run_frame(input string name, input logic [47:0] f, input int gap);
    logic [15:0] r;
    r = model_result(f);
    start_frame(name, f, gap, r);
    finish_frame(name, (f[15:0] != 16'h0000) ? 1 : 0, r, 400);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_start"}, {31'd0, expmod_start}, 32'd0);
    check({name, "_trig"}, {31'd0, tx_trigger}, 32'd0);
    check({name, "_txdata"}, {24'd0, tx_data}, 32'd0);
    check({name, "_state"}, {29'd0, state}, {29'd0, ST_RX});
    check({name, "_opnds"}, {value | exponent | modulus}, 32'd0);
    check({name, "_result"}, {16'd0, result}, 32'd0);
    check({name, "_drops"}, {24'd0, drop_count}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_100mhz);
    check_zero_outputs("rst_in");
    rst = 1'b0;
    @(negedge clk_100mhz);
    check_zero_outputs("rst_after");
    exp_drop = 0;
    last_res = 16'h0000;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [47:0] frame;
    int          starts;
    logic [15:0] res;
  } vec_t;
  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] f;
    logic [15:0] r;

    vecs[0] = '{48'h0005_0048_0431, 1, 16'h0070};
    vecs[1] = '{48'h0005_0002_0000, 0, 16'hFFFF};
    vecs[2] = '{48'h0003_0004_0007, 1, 16'h0004};
    vecs[3] = '{48'hFFFF_FFFF_FFFF, 1, 16'h0000};
    vecs[4] = '{48'h1234_0000_0001, 1, 16'h0000};
    vecs[5] = '{48'h0002_000A_FFFF, 1, 16'h0400};
    vecs[6] = '{48'h0007_0002_0100, 1, 16'h0031};

    do_reset();

    // Table vectors, including the reference job and the zero-modulus frame.
    for (int i = 0; i < 7; i++) begin
      start_frame($sformatf("vec%0d", i), vecs[i].frame, -1, vecs[i].res);
      finish_frame($sformatf("vec%0d", i), vecs[i].starts, vecs[i].res, 400);
    end

    // Random frames against the reference model.
    for (int i = 0; i < 10; i++) begin
      f[47:32] = 16'($urandom);
      f[31:16] = 16'($urandom);
      f[15:0]  = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      tx_hold  = int'($urandom_range(1, 6));
      run_frame($sformatf("rnd%0d", i), f, -1);
    end
    tx_hold = 3;

    // Gaps one cycle short of the timeout must not drop anything.
    run_frame("gap_edge", 48'h0009_0003_00C8, TO - 1);

    // Launch held off while exponent_modulus is busy.
    ext_busy = 1'b1;
    start_frame("launch_busy", 48'h0004_0003_000B, 0, 16'h0009);
    repeat (20) @(negedge clk_100mhz);
    check("launch_busy_nostart", start_cnt - s0, 0);
    check("launch_busy_held", {31'd0, busy}, 32'd1);
    ext_busy = 1'b0;
    finish_frame("launch_busy", 1, 16'h0009, 400);

    // A stray result strobe while idle is ignored.
    t0 = trig_cnt;
    inject_data = 16'hBEEF;
    inject_req++;
    repeat (10) @(negedge clk_100mhz);
    check("stray_valid_result", {16'd0, result}, {16'd0, last_res});
    check("stray_valid_trigs", trig_cnt - t0, 0);
    check("stray_valid_busy", {31'd0, busy}, 32'd0);

    // Partial frame followed by a timeout gap, then a clean frame.
    do_reset();
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    repeat (TO + 1) @(negedge clk_100mhz);
    exp_drop = 1;
    check("timeout_drop", {24'd0, drop_count}, 32'd1);
    run_frame("timeout_frame", 48'h0005_0048_0431, 0);

    // Byte landing on the timeout cycle becomes byte 0 of a new frame.
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (TO) @(negedge clk_100mhz);
    exp_drop = 2;
    run_frame("timeout_coincide", 48'h0003_0005_0011, 0);

    // Two bytes injected while waiting on the job.
    do_reset();
    f = 48'h0006_0007_00FB;
    r = model_result(f);
    start_frame("wait_inject", f, -1, r);
    repeat (5) @(negedge clk_100mhz);
    send_byte(8'h11);
    repeat (3) @(negedge clk_100mhz);
    send_byte(8'h22);
    exp_drop = 2;
    finish_frame("wait_inject", 1, r, 400);
    run_frame("after_inject", 48'h000A_0011_0D05, -1);

    // Slow transmitter, plus a byte flood that saturates the drop counter.
    tx_hold = 500;
    start_frame("slow_tx", 48'h0005_0048_0431, 0, 16'h0070);
    for (int i = 0; i < 300; i++) send_byte(8'($urandom));
    exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
    finish_frame("slow_tx", 1, 16'h0070, 3000);
    tx_hold = 3;

    // Reset while waiting on the job; the late result strobe must be ignored.
    s0 = start_cnt;
    send_frame(48'h0005_0048_0431, 0);
    repeat (10) @(negedge clk_100mhz);
    check("abort_started", start_cnt - s0, 1);
    t0 = trig_cnt;
    s0 = start_cnt;
    rst = 1'b1;
    @(negedge clk_100mhz);
    check_zero_outputs("abort_rst");
    rst = 1'b0;
    exp_drop = 0;
    last_res = 16'h0000;
    @(negedge clk_100mhz);
    check_zero_outputs("abort_after");
    repeat (60) @(negedge clk_100mhz);
    check("abort_trigs", trig_cnt - t0, 0);
    check("abort_starts", start_cnt - s0, 0);
    check_zero_outputs("abort_final");

    // Recovery after the aborted job.
    run_frame("recover", 48'h0002_0010_3039, -1);

    check("final_pending", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
